fetch_sequencer: RTL and testbench

Sequences instruction fetch from a byte-wide, single-read-port instruction memory (1-cycle read latency) on behalf of the SEQ fetch stage. On a start pulse it issues one byte read per cycle from pc, decodes icode to determine the Y86-64 instruction length (1, 2, 9 or 10 bytes), and assembles icode/ifun/rA/rB/valC/valP. It also flags memory-range and invalid-instruction errors.

---
 rtl/fetch_sequencer_if.sv | 36 +++
 rtl/fetch_sequencer.sv | 140 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Handshake and memory bus bundle for fetch_sequencer; the bench drives the master side.
// Defining FETCH_INSTR_COUNT_EN adds the instr_count signal.
interface fetch_sequencer_if #(parameter int ADDR_W = 64);
  logic              start;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              done;
  logic [3:0]        icode;
  logic [3:0]        ifun;
  logic [3:0]        rA;
  logic [3:0]        rB;
  logic [63:0]       valC;
  logic [ADDR_W-1:0] valP;
  logic              instr_valid;
  logic              imem_error;
`ifdef FETCH_INSTR_COUNT_EN
  logic [31:0]       instr_count;

  modport master (output start, pc, mem_rdata,
                  input  busy, mem_rd_en, mem_addr, done, icode, ifun, rA, rB,
                         valC, valP, instr_valid, imem_error, instr_count);
  modport slave  (input  start, pc, mem_rdata,
                  output busy, mem_rd_en, mem_addr, done, icode, ifun, rA, rB,
                         valC, valP, instr_valid, imem_error, instr_count);
`else
  modport master (output start, pc, mem_rdata,
                  input  busy, mem_rd_en, mem_addr, done, icode, ifun, rA, rB,
                         valC, valP, instr_valid, imem_error);
  modport slave  (input  start, pc, mem_rdata,
                  output busy, mem_rd_en, mem_addr, done, icode, ifun, rA, rB,
                         valC, valP, instr_valid, imem_error);
`endif
endinterface

// File: rtl/fetch_sequencer.sv
// Y86-64 instruction fetch sequencer over a byte-wide, 1-cycle-latency memory.
// Optional FETCH_INSTR_COUNT_EN adds a saturating count of valid fetches.
module fetch_sequencer #(
  parameter int MEM_SIZE = 2048,
  parameter int ADDR_W   = 64
) (
  input logic              clk,
  input logic              rst,
  fetch_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, FINISH} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base;
  logic [3:0]        cnt;
  logic [3:0]        icode_r, ifun_r, ra_r, rb_r;
  logic [63:0]       valc_r;
  logic [ADDR_W-1:0] valp_r;
  logic              valid_r, err_r;

  logic [3:0]        cur_icode, len, cnt_m2, cnt_m3;
  logic [2:0]        cidx;
  logic [ADDR_W:0]   addr_ext;
  logic              in_range, want_issue, last, range_err, issue;

  function automatic logic [3:0] instr_len(input logic [3:0] ic);
    case (ic)
      4'h2, 4'h6, 4'hA, 4'hB: instr_len = 4'd2;
      4'h7, 4'h8:             instr_len = 4'd9;
      4'h3, 4'h4, 4'h5:       instr_len = 4'd10;
      default:                instr_len = 4'd1;
    endcase
  endfunction

  // cnt = cycles spent in ISSUE: byte cnt is issued and byte cnt-1 captured.
  // Byte0 arrives when cnt==1, so length is decoded straight from mem_rdata there.
  always_comb begin
    cur_icode  = (cnt == 4'd1) ? bus.mem_rdata[7:4] : icode_r;
    len        = instr_len(cur_icode);
    addr_ext   = {1'b0, base} + (ADDR_W+1)'(cnt);
    in_range   = addr_ext < (ADDR_W+1)'(MEM_SIZE);
    want_issue = (cnt <= 4'd1) || (cnt < len);
    last       = (cnt != 4'd0) && (cnt == len);
    range_err  = (state == ISSUE) && want_issue && !in_range && !last;
    issue      = (state == ISSUE) && want_issue && in_range;
    cnt_m2     = cnt - 4'd2;
    cnt_m3     = cnt - 4'd3;
    cidx       = (len == 4'd9) ? cnt_m2[2:0] : cnt_m3[2:0];

    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = ISSUE;
      ISSUE:   if (last || range_err) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      base    <= '0;
      cnt     <= '0;
      icode_r <= 4'h0;
      ifun_r  <= 4'h0;
      ra_r    <= 4'hF;
      rb_r    <= 4'hF;
      valc_r  <= '0;
      valp_r  <= '0;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (bus.start) begin
            base    <= bus.pc;
            cnt     <= '0;
            icode_r <= 4'h0;
            ifun_r  <= 4'h0;
            ra_r    <= 4'hF;
            rb_r    <= 4'hF;
            valc_r  <= '0;
            valp_r  <= '0;
            valid_r <= 1'b0;
            err_r   <= 1'b0;
          end
        end
        ISSUE: begin
          cnt <= cnt + 4'd1;
          if (cnt == 4'd1) begin
            icode_r <= bus.mem_rdata[7:4];
            ifun_r  <= bus.mem_rdata[3:0];
          end else if (cnt == 4'd2 && (len == 4'd2 || len == 4'd10)) begin
            ra_r <= bus.mem_rdata[7:4];
            rb_r <= bus.mem_rdata[3:0];
          end else if ((len == 4'd9 && cnt >= 4'd2) || (len == 4'd10 && cnt >= 4'd3)) begin
            valc_r[{cidx, 3'b000} +: 8] <= bus.mem_rdata;
          end

          if (range_err) begin
            err_r   <= 1'b1;
            valid_r <= 1'b0;
            valp_r  <= '0;
          end else if (last) begin
            valid_r <= (cur_icode <= 4'hB);
            valp_r  <= base + ADDR_W'(len);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_INSTR_COUNT_EN
  logic [31:0] count_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count_r <= '0;
    else if (state == FINISH && valid_r && count_r != 32'hFFFF_FFFF)
      count_r <= count_r + 32'd1;
  end

  assign bus.instr_count = count_r;
`endif

  assign bus.busy        = (state == ISSUE);
  assign bus.done        = (state == FINISH);
  assign bus.mem_rd_en   = issue;
  assign bus.mem_addr    = issue ? addr_ext[ADDR_W-1:0] : '0;
  assign bus.icode       = icode_r;
  assign bus.ifun        = ifun_r;
  assign bus.rA          = ra_r;
  assign bus.rB          = rb_r;
  assign bus.valC        = valc_r;
  assign bus.valP        = valp_r;
  assign bus.instr_valid = valid_r;
  assign bus.imem_error  = err_r;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a 2048-byte, 1-cycle-latency memory model.
module tb_fetch_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [7:0]  mem [0:2047];
  logic [63:0] rd_addr_q[$];
  int          rd_cyc_q[$];

  fetch_sequencer_if #(.ADDR_W(64)) bus ();

  fetch_sequencer #(.MEM_SIZE(2048), .ADDR_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_rd_en) begin
      rd_addr_q.push_back(bus.mem_addr);
      rd_cyc_q.push_back(cyc);
      bus.mem_rdata <= mem[bus.mem_addr[10:0]];
    end
  end

  task automatic do_fetch(input logic [63:0] a, output int t0, output int td);
    @(negedge clk);
    rd_addr_q.delete();
    rd_cyc_q.delete();
    bus.start = 1'b1;
    bus.pc    = a;
    t0        = cyc;
    td        = -1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bus.done) begin
        td = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.pc = '0;
    bus.mem_rdata = 8'h00;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
    checks++; if (bus.mem_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b exp 0", bus.mem_rd_en); end
    checks++; if (bus.rA !== 4'hF || bus.rB !== 4'hF) begin errors++; $display("FAIL reset_regs got %h%h exp FF", bus.rA, bus.rB); end
    checks++; if (bus.valP !== 64'd0 || bus.valC !== 64'd0) begin errors++; $display("FAIL reset_vals got %h/%h exp 0/0", bus.valP, bus.valC); end
    checks++; if (bus.instr_valid !== 1'b0 || bus.imem_error !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b exp 00", bus.instr_valid, bus.imem_error); end
    rst = 1'b0;
  endtask

  task automatic test_halt();
    int t0, td, n0;
    mem[0] = 8'h00;
    do_fetch(64'd0, t0, td);
    n0 = 0;
    foreach (rd_addr_q[i]) if (rd_addr_q[i] == 64'd0) n0++;
    checks++; if (td !== t0 + 3) begin errors++; $display("FAIL halt_done_cycle got %0d exp %0d", td - t0, 3); end
    checks++; if (n0 !== 1) begin errors++; $display("FAIL halt_reads_addr0 got %0d exp 1", n0); end
    checks++; if (rd_cyc_q.size() == 0 || rd_cyc_q[0] !== t0 + 1) begin errors++; $display("FAIL halt_first_read got %0d reads exp issue at T+1", rd_cyc_q.size()); end
    checks++; if (bus.icode !== 4'h0 || bus.rA !== 4'hF || bus.rB !== 4'hF) begin errors++; $display("FAIL halt_fields got %h %h %h exp 0 F F", bus.icode, bus.rA, bus.rB); end
    checks++; if (bus.valP !== 64'd1) begin errors++; $display("FAIL halt_valP got %0d exp 1", bus.valP); end
    checks++; if (bus.instr_valid !== 1'b1 || bus.imem_error !== 1'b0) begin errors++; $display("FAIL halt_flags got %b%b exp 10", bus.instr_valid, bus.imem_error); end
  endtask

  task automatic test_irmovq();
    int t0, td;
    mem[112] = 8'h30; mem[113] = 8'hF8; mem[114] = 8'h08;
    for (int i = 115; i <= 121; i++) mem[i] = 8'h00;
    do_fetch(64'd112, t0, td);
    checks++; if (td !== t0 + 12) begin errors++; $display("FAIL irmovq_done_cycle got %0d exp 12", td - t0); end
    checks++; if (rd_addr_q.size() !== 10 || rd_addr_q[0] !== 64'd112 || rd_addr_q[rd_addr_q.size()-1] !== 64'd121) begin
      errors++; $display("FAIL irmovq_reads got %0d reads exp 10 at 112..121", rd_addr_q.size()); end
    checks++; if (bus.icode !== 4'h3 || bus.ifun !== 4'h0) begin errors++; $display("FAIL irmovq_icode got %h%h exp 30", bus.icode, bus.ifun); end
    checks++; if (bus.rA !== 4'hF || bus.rB !== 4'h8) begin errors++; $display("FAIL irmovq_regs got %h%h exp F8", bus.rA, bus.rB); end
    checks++; if (bus.valC !== 64'd8) begin errors++; $display("FAIL irmovq_valC got %h exp 8", bus.valC); end
    checks++; if (bus.valP !== 64'd122 || bus.instr_valid !== 1'b1) begin errors++; $display("FAIL irmovq_valP got %0d/%b exp 122/1", bus.valP, bus.instr_valid); end
  endtask

  task automatic test_jxx();
    int t0, td;
    mem[145] = 8'h70; mem[146] = 8'h8F;
    for (int i = 147; i <= 153; i++) mem[i] = 8'h00;
    do_fetch(64'd145, t0, td);
    checks++; if (td !== t0 + 11) begin errors++; $display("FAIL jxx_done_cycle got %0d exp 11", td - t0); end
    checks++; if (bus.icode !== 4'h7 || bus.ifun !== 4'h0) begin errors++; $display("FAIL jxx_icode got %h%h exp 70", bus.icode, bus.ifun); end
    checks++; if (bus.valC !== 64'h8F) begin errors++; $display("FAIL jxx_valC got %h exp 8f", bus.valC); end
    checks++; if (bus.valP !== 64'd154) begin errors++; $display("FAIL jxx_valP got %0d exp 154", bus.valP); end
    checks++; if (bus.rA !== 4'hF || bus.rB !== 4'hF) begin errors++; $display("FAIL jxx_regs got %h%h exp FF", bus.rA, bus.rB); end
  endtask

  task automatic test_range();
    int t0, td;
    mem[2045] = 8'h30; mem[2046] = 8'hF8; mem[2047] = 8'h08;
    do_fetch(64'd2045, t0, td);
    checks++; if (td !== t0 + 5) begin errors++; $display("FAIL range_done_cycle got %0d exp 5", td - t0); end
    checks++; if (rd_addr_q.size() !== 3 || rd_addr_q[rd_addr_q.size()-1] !== 64'd2047) begin
      errors++; $display("FAIL range_reads got %0d reads exp 3 ending 2047", rd_addr_q.size()); end
    checks++; if (bus.imem_error !== 1'b1 || bus.instr_valid !== 1'b0 || bus.valP !== 64'd0) begin
      errors++; $display("FAIL range_flags got err=%b vld=%b valP=%0d exp 1 0 0", bus.imem_error, bus.instr_valid, bus.valP); end
    checks++; if (bus.icode !== 4'h3 || bus.rB !== 4'h8 || bus.valC !== 64'd8) begin
      errors++; $display("FAIL range_partial got %h %h %h exp 3 8 8", bus.icode, bus.rB, bus.valC); end
    do_fetch(64'd2048, t0, td);
    checks++; if (td !== t0 + 2) begin errors++; $display("FAIL oob_done_cycle got %0d exp 2", td - t0); end
    checks++; if (rd_addr_q.size() !== 0) begin errors++; $display("FAIL oob_reads got %0d exp 0", rd_addr_q.size()); end
    checks++; if (bus.imem_error !== 1'b1 || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL oob_flags got %b%b exp 10", bus.imem_error, bus.instr_valid); end
  endtask

  task automatic test_invalid_and_busy_start();
    int t0, td, ndone;
    mem[10] = 8'hC0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.pc    = 64'd10;
    t0 = cyc; td = -1; ndone = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (cyc >= t0 + 4) bus.start = 1'b0;
      if (bus.done) begin ndone++; if (td < 0) td = cyc; end
    end
    checks++; if (td !== t0 + 3) begin errors++; $display("FAIL inv_done_cycle got %0d exp 3", td - t0); end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL busy_start_dones got %0d exp 1", ndone); end
    checks++; if (bus.instr_valid !== 1'b0 || bus.imem_error !== 1'b0) begin errors++; $display("FAIL inv_flags got %b%b exp 00", bus.instr_valid, bus.imem_error); end
    checks++; if (bus.valP !== 64'd11 || bus.icode !== 4'hC) begin errors++; $display("FAIL inv_valP got %0d/%h exp 11/c", bus.valP, bus.icode); end
  endtask

  task automatic test_reset_mid_fetch();
    int t0, td;
    @(negedge clk);
    bus.start = 1'b1;
    bus.pc    = 64'd112;
    t0 = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < t0 + 5) @(negedge clk);
    checks++; if (bus.busy !== 1'b1 || bus.icode !== 4'h3) begin errors++; $display("FAIL mid_busy got %b/%h exp 1/3", bus.busy, bus.icode); end
    rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.mem_rd_en !== 1'b0 || bus.mem_addr !== 64'd0) begin
      errors++; $display("FAIL mid_rst_bus got %b %b %h exp 0 0 0", bus.busy, bus.mem_rd_en, bus.mem_addr); end
    checks++; if (bus.icode !== 4'h0 || bus.rB !== 4'hF || bus.valC !== 64'd0) begin
      errors++; $display("FAIL mid_rst_fields got %h %h %h exp 0 F 0", bus.icode, bus.rB, bus.valC); end
    @(negedge clk);
    rst = 1'b0;
    do_fetch(64'd145, t0, td);
    checks++; if (td !== t0 + 11 || bus.valC !== 64'h8F || bus.valP !== 64'd154) begin
      errors++; $display("FAIL post_rst_fetch got dt=%0d valC=%h valP=%0d exp 11 8f 154", td - t0, bus.valC, bus.valP); end
`ifdef FETCH_INSTR_COUNT_EN
    do_fetch(64'd0, t0, td);
    do_fetch(64'd112, t0, td);
    @(negedge clk);
    checks++; if (bus.instr_count !== 32'd3) begin errors++; $display("FAIL instr_count got %0d exp 3", bus.instr_count); end
`endif
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    test_reset();
    test_halt();
    test_irmovq();
    test_jxx();
    test_range();
    test_invalid_and_busy_start();
    test_reset_mid_fetch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
